// File: rtl/and2_input_debounce.sv
// Two-channel synchronizer + counter debounce feeding the and2 gate, with a shared change strobe.
// Optional rejected-glitch counter on glitch_cnt, enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module and2_input_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_raw,
  input  logic             b_raw,
  output logic             a_clean,
  output logic             b_clean,
  output logic             chg
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  if (SYNC_STAGES < 2 || DB_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("and2_input_debounce: illegal parameter value");
  end

  localparam int CW = $clog2(DB_CYCLES + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(DB_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_PENDING} state_e;

  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [1:0]             syn;
  state_e                 state_q [2];
  state_e                 state_d [2];
  cnt_t                   cnt_q [2];
  cnt_t                   cnt_d [2];
  logic [1:0]             clean_q, clean_d;
  logic [1:0]             upd;
  logic                   chg_q, chg_d;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [1:0]             rej;
  logic [CNT_W-1:0]       glitch_q, glitch_d;
  logic [CNT_W:0]         glitch_sum;
`endif

  assign raw = {b_raw, a_raw};

  // NOTE: every sync flop is reset so the clean outputs cannot pick up a stale level after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch]  <= '0;
        state_q[ch] <= ST_STABLE;
        cnt_q[ch]   <= '0;
      end
      clean_q <= '0;
      chg_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch]  <= sync_d[ch];
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      clean_q <= clean_d;
      chg_q   <= chg_d;
    end
  end

  always_comb begin : next_state
    for (int ch = 0; ch < 2; ch++) begin
      // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
      state_d[ch] = state_q[ch];
      unique case (state_q[ch])
        ST_STABLE:  if (syn[ch] != clean_q[ch] && DB_CYCLES > 1) state_d[ch] = ST_PENDING;
        ST_PENDING: if (syn[ch] == clean_q[ch] || cnt_q[ch] == CNT_LAST) state_d[ch] = ST_STABLE;
        default:    state_d[ch] = ST_STABLE;
      endcase
    end
  end

  always_comb begin : datapath
    upd     = '0;
    clean_d = clean_q;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    rej     = '0;
`endif
    for (int ch = 0; ch < 2; ch++) begin
      syn[ch]    = sync_q[ch][SYNC_STAGES-1];
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
      cnt_d[ch]  = cnt_q[ch];
      unique case (state_q[ch])
        ST_STABLE: begin
          if (syn[ch] != clean_q[ch]) begin
            if (DB_CYCLES == 1) upd[ch]   = 1'b1;
            else                cnt_d[ch] = cnt_t'(1);
          end
        end
        ST_PENDING: begin
          if (syn[ch] == clean_q[ch]) begin
            cnt_d[ch] = '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            rej[ch]   = 1'b1;
`endif
          end else if (cnt_q[ch] == CNT_LAST) begin
            upd[ch]   = 1'b1;
            cnt_d[ch] = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + cnt_t'(1);
          end
        end
        default: cnt_d[ch] = '0;
      endcase
      if (upd[ch]) clean_d[ch] = syn[ch];
    end
    // One strobe covers simultaneous updates on both channels.
    chg_d = |upd;
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  always_comb begin : glitch_next
    glitch_sum = {1'b0, glitch_q} + (CNT_W+1)'(rej[0]) + (CNT_W+1)'(rej[1]);
    glitch_d   = glitch_sum[CNT_W] ? '1 : glitch_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glitch_q <= '0;
    else        glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`endif

  assign a_clean = clean_q[0];
  assign b_clean = clean_q[1];
  assign chg     = chg_q;

endmodule

// File: tb/tb_and2_input_debounce.sv
// Scoreboard bench for and2_input_debounce at default parameters; stimulus pushes expected
// clean-output updates with their arrival cycle, a monitor pops them on each chg pulse.
module tb_and2_input_debounce;

  typedef struct {
    logic a;
    logic b;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a_clean, b_clean, chg;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic [1:0] prev_clean = 2'b00;

  and2_input_debounce #(.SYNC_STAGES(2), .DB_CYCLES(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_raw   (a_raw),
    .b_raw   (b_raw),
    .a_clean (a_clean),
    .b_clean (b_clean),
    .chg     (chg)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected update lands `lat` edges after the inputs were driven.
  task automatic expect_upd(input logic a, input logic b, input int lat);
    exp_t e;
    e.a = a;
    e.b = b;
    e.cyc = cyc + lat;
    sb_q.push_back(e);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(1);
    check("reset_a_clean", a_clean, 0);
    check("reset_b_clean", b_clean, 0);
    check("reset_chg", chg, 0);
    rst_n = 1'b1;
  endtask

  // Monitor: every chg pulse must match the next scoreboard entry in value and cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_clean = 2'b00;
    end else begin
      if ({b_clean, a_clean} != prev_clean) check("chg_with_update", chg, 1);
      if (chg) begin
        if (sb_q.size() == 0) begin
          check("unexpected_chg", 0, 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("upd_a_clean", a_clean, e.a);
          check("upd_b_clean", b_clean, e.b);
          check("upd_cycle", cyc, e.cyc);
        end
      end
      prev_clean = {b_clean, a_clean};
    end
  end

  initial begin
    // 1. Reset held with raw inputs high, then release.
    a_raw = 1'b1;
    b_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("rst_hold_a", a_clean, 0);
      check("rst_hold_b", b_clean, 0);
      check("rst_hold_chg", chg, 0);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("rst_glitch_cnt", glitch_cnt, 0);
`endif
    rst_n = 1'b1;
    expect_upd(1, 1, 6);
    tick(5);
    check("pre_latency_a", a_clean, 0);
    tick(5);
    check("c_after_reset", a_clean & b_clean, 1);

    // 2. Three-cycle glitch on A is rejected.
    a_raw = 1'b0;
    b_raw = 1'b0;
    pulse_reset();
    a_raw = 1'b1;
    tick(3);
    a_raw = 1'b0;
    tick(10);
    check("glitch_a_clean", a_clean, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_cnt_one", glitch_cnt, 1);
`endif

    // Boundary: a four-cycle pulse is just long enough to pass, and its fall passes too.
    a_raw = 1'b1;
    expect_upd(1, 0, 6);
    tick(4);
    a_raw = 1'b0;
    expect_upd(0, 0, 6);
    tick(10);

    // 3. Accept A, then B; and2 output rises. Then both fall separately.
    a_raw = 1'b1;
    expect_upd(1, 0, 6);
    tick(10);
    b_raw = 1'b1;
    expect_upd(1, 1, 6);
    tick(10);
    check("c_after_accept", a_clean & b_clean, 1);
    a_raw = 1'b0;
    expect_upd(0, 1, 6);
    tick(10);
    b_raw = 1'b0;
    expect_upd(0, 0, 6);
    tick(10);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_cnt_unchanged", glitch_cnt, 1);
`endif

    // 4. Simultaneous rise: one chg pulse, both outputs together.
    a_raw = 1'b1;
    b_raw = 1'b1;
    expect_upd(1, 1, 6);
    tick(10);
    check("c_simultaneous", a_clean & b_clean, 1);

    // 5. Reset while A is PENDING discards progress.
    a_raw = 1'b0;
    b_raw = 1'b0;
    pulse_reset();
    tick(2);
    a_raw = 1'b1;
    tick(4);
    pulse_reset();
    expect_upd(1, 0, 6);
    tick(5);
    check("pending_discarded", a_clean, 0);
    tick(5);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // 6. Simultaneous rejections add two; then saturation at all-ones.
    a_raw = 1'b0;
    pulse_reset();
    a_raw = 1'b1;
    b_raw = 1'b1;
    tick(3);
    a_raw = 1'b0;
    b_raw = 1'b0;
    tick(8);
    check("glitch_cnt_two", glitch_cnt, 2);
    for (int i = 0; i < 300; i++) begin
      a_raw = 1'b1;
      tick(2);
      a_raw = 1'b0;
      tick(2);
    end
    tick(6);
    check("glitch_cnt_sat", glitch_cnt, 255);
    check("sat_a_clean", a_clean, 0);
    a_raw = 1'b1;
    tick(2);
    a_raw = 1'b0;
    tick(8);
    check("glitch_cnt_hold", glitch_cnt, 255);
`endif

    tick(3);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
